lsu_ecc_scrub: RTL and testbench
================================

Name: lsu_ecc_scrub

Overview:
Parametrised multi-bank DCCM ECC checker with automatic correction write-back (scrub). It checks NUM_BANKS read banks in parallel, registers the corrected data and error flags, and queues one corrected-word write-back per bank with single-bit errors. Write-backs are issued to the DCCM arbiter over a valid/ready handshake. It sits between the DCCM read path and the LSU DC4 merge logic.

Parameters:
DATA_WIDTH, 32, data bits per bank; legal values 32 and 64.
ECC_WIDTH, 7, check bits per bank: r Hamming bits plus 1 overall parity; 7 for 32, 8 for 64.
NUM_BANKS, 2, number of banks checked in parallel; legal range 1..4.
ADDR_WIDTH, 16, DCCM word-address width.
CNT_WIDTH, 16, width of the error counters.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
ecc_disable  in  1  suppresses detection, correction and write-back
chk_valid  in  1  read data valid this cycle
chk_bank_en  in  NUM_BANKS  per-bank check enable
chk_addr  in  NUM_BANKS*ADDR_WIDTH  word address per bank
rd_data  in  NUM_BANKS*DATA_WIDTH  raw bank data
rd_ecc  in  NUM_BANKS*ECC_WIDTH  raw bank check bits
out_valid  out  1  registered result valid
out_data  out  NUM_BANKS*DATA_WIDTH  corrected data
out_sec  out  NUM_BANKS  single error corrected, per bank
out_ded  out  NUM_BANKS  double error detected, per bank
wb_valid  out  1  write-back request
wb_ready  in  1  arbiter accepts write-back
wb_addr  out  ADDR_WIDTH  write-back address
wb_data  out  DATA_WIDTH  corrected data
wb_ecc  out  ECC_WIDTH  freshly encoded check bits
wb_busy  out  1  write-back queue non-empty
wb_drop  out  1  one-cycle pulse: a correction was not queued
cnt_clr  in  1  synchronous clear of the counters
sec_cnt  out  CNT_WIDTH  saturating single-error count
ded_cnt  out  CNT_WIDTH  saturating double-error count

Behaviour:
- Code: extended Hamming. Check bit k sits at code position 2^k. Data fills the non-power-of-two positions 1..DATA_WIDTH+r in ascending order. ecc[r] is the XOR of all data and check bits.
- Decode, per bank b, when chk_valid & chk_bank_en[b] & ~ecc_disable:
  - syndrome 0 and parity OK: clean.
  - parity mismatch and syndrome in 0..DATA_WIDTH+r: SEC; flip the addressed bit (syndrome 0 means the parity bit itself, data unchanged).
  - syndrome non-zero and parity OK: DED.
  - parity mismatch and syndrome > DATA_WIDTH+r: DED.
  - DED passes data through unmodified.
- Pipeline: exactly one cycle of latency. out_* are registered. out_valid = chk_valid delayed one cycle. Disabled banks produce raw data with flags 0.
- Reset values: all outputs 0; queue empty; FSM in IDLE.
- Queue: one slot per bank holding addr and corrected data. A slot is loaded on a SEC when the slot is empty. On a SEC when the slot is full, the capture is dropped and wb_drop pulses (one pulse per cycle regardless of how many banks drop). DED is never queued.
- FSM IDLE: on any slot full, move to REQ with the lowest full bank index selected.
- FSM REQ: wb_valid=1; wb_addr, wb_data and wb_ecc are stable until accepted. On wb_valid & wb_ready, free that slot. Then either select the next full slot (by index, with wrap) and stay in REQ, or return to IDLE if none remain.
- A slot freed in cycle N can be reloaded by a SEC decoded in cycle N.
- wb_busy = any slot full.
- ecc_disable does not cancel queued write-backs.
- Counters: each increments by the number of banks flagged that cycle, saturating at all-ones. cnt_clr has priority over increment in the same cycle.
- Reset asserted mid-request drops wb_valid immediately and empties the queue.

Optional Feature:
- LSU_ECC_SCRUB_ERR_LOG_EN defined adds outputs:
  - err_log_valid (1)
  - err_log_addr (ADDR_WIDTH)
  - err_log_bank (2)
  - err_log_syn (ECC_WIDTH)
  - err_log_ded (1)
- The log captures the first SEC or DED after reset or cnt_clr. If several banks flag in the same cycle, the lowest bank wins. The log holds until cnt_clr.
- Undefined: these ports and their registers are absent; all other behaviour is unchanged.

Test Plan:
- DATA_WIDTH=32, bank0 data 0xDEADBEEF, correct ECC with data bit 5 flipped -> next cycle out_data[31:0]=0xDEADBEEF, out_sec=2'b01, sec_cnt=1, then wb_valid with wb_addr=chk_addr0 and wb_data=0xDEADBEEF.
- Two flipped data bits on bank1 -> out_ded=2'b10, data passed unchanged, ded_cnt=1, no wb_valid.
- SEC on both banks in the same cycle with wb_ready held low 3 cycles -> wb_valid holds bank0 request stable; after accept, bank1 request follows in the next cycle; then IDLE, wb_busy=0.
- Second SEC on bank0 while its slot is still full -> wb_drop pulses 1 cycle, sec_cnt still increments, only one write-back issued.
- sec_cnt preloaded to 0xFFFF by repeated SECs -> stays at 0xFFFF; cnt_clr together with a SEC -> 0.
- ecc_disable=1 with corrupted data -> raw data out, flags 0, counters unchanged; assert rst during REQ -> wb_valid=0 in the same cycle.

Source files
------------

// File: rtl/lsu_ecc_scrub.sv
// Multi-bank DCCM extended-Hamming checker with one-cycle corrected output and a per-bank
// scrub write-back queue. Define LSU_ECC_SCRUB_ERR_LOG_EN to add the first-error log ports.
module lsu_ecc_scrub #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ECC_WIDTH  = 7,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             ecc_disable_i,
    input  logic                             chk_valid_i,
    input  logic [NUM_BANKS-1:0]             chk_bank_en_i,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  chk_addr_i,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  rd_data_i,
    input  logic [NUM_BANKS*ECC_WIDTH-1:0]   rd_ecc_i,
    output logic                             out_valid_o,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  out_data_o,
    output logic [NUM_BANKS-1:0]             out_sec_o,
    output logic [NUM_BANKS-1:0]             out_ded_o,
    output logic                             wb_valid_o,
    input  logic                             wb_ready_i,
    output logic [ADDR_WIDTH-1:0]            wb_addr_o,
    output logic [DATA_WIDTH-1:0]            wb_data_o,
    output logic [ECC_WIDTH-1:0]             wb_ecc_o,
    output logic                             wb_busy_o,
    output logic                             wb_drop_o,
    input  logic                             cnt_clr_i,
`ifdef LSU_ECC_SCRUB_ERR_LOG_EN
    output logic                             err_log_valid_o,
    output logic [ADDR_WIDTH-1:0]            err_log_addr_o,
    output logic [1:0]                       err_log_bank_o,
    output logic [ECC_WIDTH-1:0]             err_log_syn_o,
    output logic                             err_log_ded_o,
`endif
    output logic [CNT_WIDTH-1:0]             sec_cnt_o,
    output logic [CNT_WIDTH-1:0]             ded_cnt_o
);

    localparam int unsigned R    = ECC_WIDTH - 1;
    localparam int unsigned NPos = DATA_WIDTH + R;
    localparam int unsigned SelW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic {StIdle, StReq} state_e;

    // Check bit k covers every code position with bit k set; data skips powers of two.
    function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
        logic [ECC_WIDTH-1:0] e;
        int unsigned j;
        e = '0;
        j = 0;
        for (int unsigned p = 1; p <= NPos; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int unsigned k = 0; k < R; k++) begin
                    if (p[k]) e[k] = e[k] ^ d[j];
                end
                j++;
            end
        end
        e[R] = ^{d, e[R-1:0]};
        return e;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] bit_flip(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [R-1:0] syn);
        logic [DATA_WIDTH-1:0] o;
        int unsigned j;
        o = d;
        j = 0;
        for (int unsigned p = 1; p <= NPos; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (p == 32'(syn)) o[j] = ~o[j];
                j++;
            end
        end
        return o;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [2:0] n);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + {{(CNT_WIDTH - 2){1'b0}}, n};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    logic [NUM_BANKS-1:0]            chk_en, par_err, sec_now, ded_now;
    logic [R-1:0]                    syn [NUM_BANKS];
    logic [NUM_BANKS*DATA_WIDTH-1:0] fix_data;

    always_comb begin
        logic [DATA_WIDTH-1:0] raw;
        logic [ECC_WIDTH-1:0]  chk;
        logic [ECC_WIDTH-1:0]  recomp;
        raw      = '0;
        chk      = '0;
        recomp   = '0;
        chk_en   = {NUM_BANKS{chk_valid_i & ~ecc_disable_i}} & chk_bank_en_i;
        fix_data = rd_data_i;
        par_err  = '0;
        sec_now  = '0;
        ded_now  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            raw        = rd_data_i[b*DATA_WIDTH +: DATA_WIDTH];
            chk        = rd_ecc_i[b*ECC_WIDTH +: ECC_WIDTH];
            recomp     = ecc_encode(raw);
            syn[b]     = recomp[R-1:0] ^ chk[R-1:0];
            par_err[b] = ^{raw, chk};
            sec_now[b] = chk_en[b] & par_err[b] & (32'(syn[b]) <= NPos);
            ded_now[b] = chk_en[b] & (par_err[b] ? (32'(syn[b]) > NPos) : (syn[b] != '0));
            if (sec_now[b]) fix_data[b*DATA_WIDTH +: DATA_WIDTH] = bit_flip(raw, syn[b]);
        end
    end

    state_e                state_q, state_d;
    logic [SelW-1:0]       sel_q, sel_d;
    logic [NUM_BANKS-1:0]  slot_full_q, slot_full_d, slot_free, slot_load, drop_now;
    logic [ADDR_WIDTH-1:0] slot_addr_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0] slot_data_q [NUM_BANKS];

    // A slot released by this cycle's handshake may be refilled by this cycle's SEC.
    always_comb begin
        slot_free   = '0;
        slot_load   = '0;
        drop_now    = '0;
        slot_full_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            slot_free[b]   = (state_q == StReq) & wb_ready_i & (int'(sel_q) == b);
            slot_load[b]   = sec_now[b] & (~slot_full_q[b] | slot_free[b]);
            drop_now[b]    = sec_now[b] & slot_full_q[b] & ~slot_free[b];
            slot_full_d[b] = (slot_full_q[b] & ~slot_free[b]) | slot_load[b];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_full_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                slot_addr_q[b] <= '0;
                slot_data_q[b] <= '0;
            end
        end else begin
            slot_full_q <= slot_full_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (slot_load[b]) begin
                    slot_addr_q[b] <= chk_addr_i[b*ADDR_WIDTH +: ADDR_WIDTH];
                    slot_data_q[b] <= fix_data[b*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        logic [SelW-1:0] idx;
        idx     = '0;
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (|slot_full_q) begin
                    state_d = StReq;
                    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
                        if (slot_full_q[b]) sel_d = SelW'(b);
                    end
                end
            end
            StReq: begin
                if (wb_ready_i) begin
                    state_d = StIdle;
                    // Descending offset so the nearest full slot after sel_q wins.
                    for (int unsigned off = NUM_BANKS; off >= 1; off--) begin
                        idx = SelW'((32'(sel_q) + off) % NUM_BANKS);
                        if (slot_full_d[idx]) begin
                            state_d = StReq;
                            sel_d   = idx;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wb_valid_o = (state_q == StReq);
        wb_addr_o  = slot_addr_q[sel_q];
        wb_data_o  = slot_data_q[sel_q];
        wb_ecc_o   = ecc_encode(slot_data_q[sel_q]);
        wb_busy_o  = |slot_full_q;
    end

    logic                            out_valid_q, drop_q;
    logic [NUM_BANKS*DATA_WIDTH-1:0] out_data_q;
    logic [NUM_BANKS-1:0]            out_sec_q, out_ded_q;
    logic [CNT_WIDTH-1:0]            sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;

    always_comb begin
        logic [2:0] sec_sum;
        logic [2:0] ded_sum;
        sec_sum = '0;
        ded_sum = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            sec_sum = sec_sum + {2'b00, sec_now[b]};
            ded_sum = ded_sum + {2'b00, ded_now[b]};
        end
        sec_cnt_d = cnt_clr_i ? '0 : sat_add(sec_cnt_q, sec_sum);
        ded_cnt_d = cnt_clr_i ? '0 : sat_add(ded_cnt_q, ded_sum);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sec_q   <= '0;
            out_ded_q   <= '0;
            drop_q      <= 1'b0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
        end else begin
            out_valid_q <= chk_valid_i;
            out_data_q  <= fix_data;
            out_sec_q   <= sec_now;
            out_ded_q   <= ded_now;
            drop_q      <= |drop_now;
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sec_o   = out_sec_q;
    assign out_ded_o   = out_ded_q;
    assign wb_drop_o   = drop_q;
    assign sec_cnt_o   = sec_cnt_q;
    assign ded_cnt_o   = ded_cnt_q;

`ifdef LSU_ECC_SCRUB_ERR_LOG_EN
    logic                  log_valid_q, log_valid_d, log_ded_q, log_ded_d;
    logic [ADDR_WIDTH-1:0] log_addr_q, log_addr_d;
    logic [1:0]            log_bank_q, log_bank_d;
    logic [ECC_WIDTH-1:0]  log_syn_q, log_syn_d;

    always_comb begin
        log_valid_d = log_valid_q;
        log_addr_d  = log_addr_q;
        log_bank_d  = log_bank_q;
        log_syn_d   = log_syn_q;
        log_ded_d   = log_ded_q;
        if (cnt_clr_i) begin
            log_valid_d = 1'b0;
        end else if (!log_valid_q && |(sec_now | ded_now)) begin
            log_valid_d = 1'b1;
            for (int b = NUM_BANKS - 1; b >= 0; b--) begin
                if (sec_now[b] | ded_now[b]) begin
                    log_addr_d = chk_addr_i[b*ADDR_WIDTH +: ADDR_WIDTH];
                    log_bank_d = 2'(b);
                    log_syn_d  = {par_err[b], syn[b]};
                    log_ded_d  = ded_now[b];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_bank_q  <= '0;
            log_syn_q   <= '0;
            log_ded_q   <= 1'b0;
        end else begin
            log_valid_q <= log_valid_d;
            log_addr_q  <= log_addr_d;
            log_bank_q  <= log_bank_d;
            log_syn_q   <= log_syn_d;
            log_ded_q   <= log_ded_d;
        end
    end

    assign err_log_valid_o = log_valid_q;
    assign err_log_addr_o  = log_addr_q;
    assign err_log_bank_o  = log_bank_q;
    assign err_log_syn_o   = log_syn_q;
    assign err_log_ded_o   = log_ded_q;
`else
    // Without the log, syndromes feed only the flag and correction logic above.
`endif

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Self-checking bench for lsu_ecc_scrub (default parameters, error log disabled).
// Reference model treats the syndrome as the XOR of the positions of all set code bits.
module tb_lsu_ecc_scrub;

    localparam int DW = 32;
    localparam int EW = 7;
    localparam int NB = 2;
    localparam int AW = 16;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ecc_disable = 1'b0;
    logic             chk_valid = 1'b0;
    logic [NB-1:0]    chk_bank_en = '0;
    logic [NB*AW-1:0] chk_addr = '0;
    logic [NB*DW-1:0] rd_data = '0;
    logic [NB*EW-1:0] rd_ecc = '0;
    logic             wb_ready = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             out_valid;
    logic [NB*DW-1:0] out_data;
    logic [NB-1:0]    out_sec, out_ded;
    logic             wb_valid, wb_busy, wb_drop;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic [EW-1:0]    wb_ecc;
    logic [CW-1:0]    sec_cnt, ded_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int dpos [DW];

    lsu_ecc_scrub dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ecc_disable_i(ecc_disable),
        .chk_valid_i  (chk_valid),
        .chk_bank_en_i(chk_bank_en),
        .chk_addr_i   (chk_addr),
        .rd_data_i    (rd_data),
        .rd_ecc_i     (rd_ecc),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_sec_o    (out_sec),
        .out_ded_o    (out_ded),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .wb_addr_o    (wb_addr),
        .wb_data_o    (wb_data),
        .wb_ecc_o     (wb_ecc),
        .wb_busy_o    (wb_busy),
        .wb_drop_o    (wb_drop),
        .cnt_clr_i    (cnt_clr),
        .sec_cnt_o    (sec_cnt),
        .ded_cnt_o    (ded_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] m_encode(input logic [DW-1:0] d);
        int x;
        x = 0;
        for (int j = 0; j < DW; j++) if (d[j]) x = x ^ dpos[j];
        return {^d ^ ^x[5:0], x[5:0]};
    endfunction

    function automatic logic [38:0] cw_of(input logic [DW-1:0] d);
        return {m_encode(d), d};
    endfunction

    // Returns {ded, sec, corrected data}.
    function automatic logic [33:0] m_decode(input logic [DW-1:0] d, input logic [EW-1:0] e);
        int x;
        logic par, sec, ded;
        logic [DW-1:0] c;
        x = 0;
        for (int j = 0; j < DW; j++) if (d[j]) x = x ^ dpos[j];
        for (int k = 0; k < 6; k++) if (e[k]) x = x ^ (1 << k);
        par = ^{d, e};
        c = d;
        sec = 1'b0;
        ded = 1'b0;
        if (par) begin
            if (x <= 38) begin
                sec = 1'b1;
                for (int j = 0; j < DW; j++) if (dpos[j] == x) c[j] = ~c[j];
            end else begin
                ded = 1'b1;
            end
        end else if (x != 0) begin
            ded = 1'b1;
        end
        return {ded, sec, c};
    endfunction

    function automatic logic [38:0] corrupt(input logic [38:0] cw, input int n);
        int a, b, c;
        logic [38:0] r;
        r = cw;
        a = $urandom_range(38);
        do b = $urandom_range(38); while (b == a);
        do c = $urandom_range(38); while (c == a || c == b);
        if (n >= 1) r[a] = ~r[a];
        if (n >= 2) r[b] = ~r[b];
        if (n >= 3) r[c] = ~r[c];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [38:0] c0, input logic [38:0] c1);
        chk_valid   = 1'b1;
        chk_bank_en = en;
        chk_addr    = {a1, a0};
        rd_data     = {c1[31:0], c0[31:0]};
        rd_ecc      = {c1[38:32], c0[38:32]};
    endtask

    task automatic clear_cnt;
        chk_valid = 1'b0;
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
    endtask

    task automatic wait_wb(output bit seen);
        for (int i = 0; i < 8; i++) begin
            if (wb_valid === 1'b1) break;
            tick;
        end
        seen = (wb_valid === 1'b1);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_sec, out_ded, wb_valid, wb_busy, wb_drop} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0",
                     {out_valid, out_sec, out_ded, wb_valid, wb_busy, wb_drop});
        end
        n_checks++;
        if ({out_data, wb_addr, wb_data, wb_ecc, sec_cnt, ded_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0",
                     {out_data, wb_addr, wb_data, wb_ecc, sec_cnt, ded_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        tick;
    endtask

    task automatic test_sec_single;
        logic [38:0] cw;
        bit seen;
        clear_cnt;
        cw = cw_of(32'hDEADBEEF);
        cw[5] = ~cw[5];
        drive(2'b01, 16'h0123, 16'h0000, cw, cw_of(32'h0));
        tick;
        chk_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sec_valid: got %b want 1", out_valid);
        end
        n_checks++;
        if (out_data[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sec_data: got %h want deadbeef", out_data[31:0]);
        end
        n_checks++;
        if ({out_sec, out_ded} !== 4'b0100) begin
            n_fail++; $display("FAIL sec_flags: got %b want 0100", {out_sec, out_ded});
        end
        n_checks++;
        if (sec_cnt !== 16'd1) begin
            n_fail++; $display("FAIL sec_cnt: got %0d want 1", sec_cnt);
        end
        wait_wb(seen);
        n_checks++;
        if (!seen || wb_addr !== 16'h0123 || wb_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sec_wb: got v=%b a=%h d=%h want 1 0123 deadbeef",
                     wb_valid, wb_addr, wb_data);
        end
        n_checks++;
        if (wb_ecc !== m_encode(32'hDEADBEEF)) begin
            n_fail++; $display("FAIL sec_wb_ecc: got %h want %h", wb_ecc, m_encode(32'hDEADBEEF));
        end
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        n_checks++;
        if ({wb_valid, wb_busy} !== 2'b00) begin
            n_fail++; $display("FAIL sec_wb_done: got %b want 00", {wb_valid, wb_busy});
        end
    endtask

    task automatic test_ded;
        logic [31:0] d;
        logic [38:0] cw;
        bit seen;
        clear_cnt;
        d = $urandom;
        cw = cw_of(d);
        cw[3] = ~cw[3];
        cw[17] = ~cw[17];
        drive(2'b10, 16'h0000, 16'h0456, cw_of(32'h0), cw);
        tick;
        chk_valid = 1'b0;
        n_checks++;
        if ({out_sec, out_ded} !== 4'b0010) begin
            n_fail++; $display("FAIL ded_flags: got %b want 0010", {out_sec, out_ded});
        end
        n_checks++;
        if (out_data[63:32] !== cw[31:0]) begin
            n_fail++; $display("FAIL ded_data: got %h want %h", out_data[63:32], cw[31:0]);
        end
        n_checks++;
        if ({ded_cnt, sec_cnt} !== {16'd1, 16'd0}) begin
            n_fail++; $display("FAIL ded_cnt: got %0d/%0d want 1/0", ded_cnt, sec_cnt);
        end
        seen = 1'b0;
        repeat (5) begin
            seen = seen | wb_valid | wb_busy;
            tick;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL ded_no_wb: got %b want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] da, db;
        logic [38:0] c0, c1;
        bit seen;
        clear_cnt;
        da = $urandom;
        db = $urandom;
        c0 = cw_of(da);
        c1 = cw_of(db);
        c0 = c0 ^ (39'd1 << $urandom_range(31));
        c1 = c1 ^ (39'd1 << $urandom_range(31));
        drive(2'b11, 16'h0AAA, 16'h0BBB, c0, c1);
        tick;
        chk_valid = 1'b0;
        n_checks++;
        if ({out_sec, sec_cnt} !== {2'b11, 16'd2}) begin
            n_fail++; $display("FAIL b2b_sec: got %b/%0d want 11/2", out_sec, sec_cnt);
        end
        wait_wb(seen);
        n_checks++;
        if (!seen || wb_addr !== 16'h0AAA || wb_data !== da) begin
            n_fail++; $display("FAIL b2b_first: got %b %h %h want 1 0aaa %h",
                               wb_valid, wb_addr, wb_data, da);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if ({wb_valid, wb_addr, wb_data} !== {1'b1, 16'h0AAA, da}) begin
                n_fail++; $display("FAIL b2b_hold: got %b %h %h want 1 0aaa %h",
                                   wb_valid, wb_addr, wb_data, da);
            end
        end
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        n_checks++;
        if ({wb_valid, wb_addr, wb_data, wb_ecc} !== {1'b1, 16'h0BBB, db, m_encode(db)}) begin
            n_fail++; $display("FAIL b2b_second: got %b %h %h %h want 1 0bbb %h %h",
                               wb_valid, wb_addr, wb_data, wb_ecc, db, m_encode(db));
        end
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        n_checks++;
        if ({wb_valid, wb_busy} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_idle: got %b want 00", {wb_valid, wb_busy});
        end
    endtask

    task automatic test_drop;
        logic [31:0] da, db;
        logic [38:0] c;
        bit seen;
        clear_cnt;
        da = $urandom;
        db = $urandom;
        c = cw_of(da);
        c[9] = ~c[9];
        drive(2'b01, 16'h0111, 16'h0, c, cw_of(32'h0));
        tick;
        n_checks++;
        if (wb_drop !== 1'b0) begin
            n_fail++; $display("FAIL drop_first: got %b want 0", wb_drop);
        end
        c = cw_of(db);
        c[36] = ~c[36];
        drive(2'b01, 16'h0222, 16'h0, c, cw_of(32'h0));
        tick;
        chk_valid = 1'b0;
        n_checks++;
        if ({wb_drop, out_sec, sec_cnt} !== {1'b1, 2'b01, 16'd2}) begin
            n_fail++; $display("FAIL drop_pulse: got %b %b %0d want 1 01 2",
                               wb_drop, out_sec, sec_cnt);
        end
        tick;
        n_checks++;
        if (wb_drop !== 1'b0) begin
            n_fail++; $display("FAIL drop_end: got %b want 0", wb_drop);
        end
        wait_wb(seen);
        n_checks++;
        if (!seen || wb_addr !== 16'h0111 || wb_data !== da) begin
            n_fail++; $display("FAIL drop_wb: got %b %h %h want 1 0111 %h",
                               wb_valid, wb_addr, wb_data, da);
        end
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        n_checks++;
        if ({wb_valid, wb_busy} !== 2'b00) begin
            n_fail++; $display("FAIL drop_single_wb: got %b want 00", {wb_valid, wb_busy});
        end
    endtask

    task automatic test_disable;
        logic [31:0] d0, d1;
        logic [38:0] c0, c1;
        bit seen;
        clear_cnt;
        d0 = $urandom;
        d1 = $urandom;
        c0 = cw_of(d0);
        c1 = cw_of(d1);
        c0[12] = ~c0[12];
        c1[1] = ~c1[1];
        c1[30] = ~c1[30];
        ecc_disable = 1'b1;
        drive(2'b11, 16'h0C00, 16'h0C01, c0, c1);
        tick;
        chk_valid = 1'b0;
        n_checks++;
        if (out_data !== {c1[31:0], c0[31:0]}) begin
            n_fail++; $display("FAIL dis_data: got %h want %h", out_data, {c1[31:0], c0[31:0]});
        end
        n_checks++;
        if ({out_sec, out_ded, wb_busy, sec_cnt, ded_cnt} !== '0) begin
            n_fail++; $display("FAIL dis_flags: got %b %b %b %0d %0d want all 0",
                               out_sec, out_ded, wb_busy, sec_cnt, ded_cnt);
        end
        ecc_disable = 1'b0;
        drive(2'b10, 16'h0, 16'h0D0D, cw_of(32'h0), c0 ^ (39'd1 << 12) ^ (39'd1 << 20));
        tick;
        chk_valid = 1'b0;
        ecc_disable = 1'b1;
        wait_wb(seen);
        n_checks++;
        if (!seen || wb_addr !== 16'h0D0D || wb_data !== d0) begin
            n_fail++; $display("FAIL dis_keep_wb: got %b %h %h want 1 0d0d %h",
                               wb_valid, wb_addr, wb_data, d0);
        end
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        ecc_disable = 1'b0;
    endtask

    task automatic test_random;
        logic [38:0] c [NB];
        logic [33:0] m;
        logic [NB*DW-1:0] exp_data;
        logic [NB-1:0] exp_sec, exp_ded, en;
        logic v;
        int sec_tot, ded_tot, r;
        clear_cnt;
        wb_ready = 1'b1;
        sec_tot = 0;
        ded_tot = 0;
        for (int it = 0; it < 200; it++) begin
            v = ($urandom_range(3) != 0);
            en = NB'($urandom);
            for (int b = 0; b < NB; b++) begin
                r = $urandom_range(9);
                c[b] = corrupt(cw_of($urandom), (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3);
                m = m_decode(c[b][31:0], c[b][38:32]);
                if (v && en[b]) begin
                    exp_data[b*DW +: DW] = m[31:0];
                    exp_sec[b] = m[32];
                    exp_ded[b] = m[33];
                end else begin
                    exp_data[b*DW +: DW] = c[b][31:0];
                    exp_sec[b] = 1'b0;
                    exp_ded[b] = 1'b0;
                end
                sec_tot += int'(exp_sec[b]);
                ded_tot += int'(exp_ded[b]);
            end
            drive(en, 16'($urandom), 16'($urandom), c[0], c[1]);
            chk_valid = v;
            tick;
            n_checks++;
            if ({out_valid, out_sec, out_ded} !== {v, exp_sec, exp_ded}) begin
                n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", it,
                                   {out_valid, out_sec, out_ded}, {v, exp_sec, exp_ded});
            end
            if (v) begin
                n_checks++;
                if (out_data !== exp_data) begin
                    n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", it, out_data,
                                       exp_data);
                end
            end
            n_checks++;
            if ({sec_cnt, ded_cnt} !== {16'(sec_tot), 16'(ded_tot)}) begin
                n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", it,
                                   sec_cnt, ded_cnt, sec_tot, ded_tot);
            end
        end
        chk_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wb_busy === 1'b0) break;
            tick;
        end
        n_checks++;
        if (wb_busy !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain: got %b want 0", wb_busy);
        end
        wb_ready = 1'b0;
    endtask

    task automatic test_saturate;
        logic [38:0] c0, c1;
        clear_cnt;
        wb_ready = 1'b1;
        c0 = cw_of(32'h1234_5678) ^ (39'd1 << 33);
        c1 = cw_of(32'h9ABC_DEF0) ^ (39'd1 << 7);
        drive(2'b11, 16'h0E00, 16'h0E01, c0, c1);
        repeat (32767) tick;
        n_checks++;
        if (sec_cnt !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_pre: got %h want fffe", sec_cnt);
        end
        tick;
        n_checks++;
        if (sec_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hit: got %h want ffff", sec_cnt);
        end
        tick;
        n_checks++;
        if (sec_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want ffff", sec_cnt);
        end
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        chk_valid = 1'b0;
        n_checks++;
        if ({out_sec, sec_cnt} !== {2'b11, 16'h0000}) begin
            n_fail++; $display("FAIL sat_clr: got %b %h want 11 0000", out_sec, sec_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            if (wb_busy === 1'b0) break;
            tick;
        end
        wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid_req;
        logic [38:0] c;
        bit seen;
        c = cw_of(32'h0F0F_00FF);
        c[22] = ~c[22];
        drive(2'b01, 16'h0F00, 16'h0, c, cw_of(32'h0));
        tick;
        chk_valid = 1'b0;
        wait_wb(seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rstreq_wb: got %b want 1", wb_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wb_valid, wb_busy, out_valid, sec_cnt} !== '0) begin
            n_fail++; $display("FAIL rstreq_async: got %b %b %b %0d want 0 0 0 0",
                               wb_valid, wb_busy, out_valid, sec_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        tick;
        n_checks++;
        if ({wb_valid, wb_busy} !== 2'b00) begin
            n_fail++; $display("FAIL rstreq_after: got %b want 00", {wb_valid, wb_busy});
        end
    endtask

    initial begin
        int j;
        j = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                dpos[j] = p;
                j++;
            end
        end
        test_reset;
        test_sec_single;
        test_ded;
        test_back_to_back;
        test_drop;
        test_disable;
        test_random;
        test_saturate;
        test_reset_mid_req;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
